dac_serial_receiver: RTL and testbench
======================================

Name: dac_serial_receiver

Overview:
- Slave-side receiver for the 3-wire DAC programming interface (serial clock, active-low sync, data).
- Oversamples the three lines in the local `clk` domain and deserializes MSB-first frames.
- Pushes each complete, well-formed frame into a small FWFT FIFO with a valid/ready output.
- Used for loopback checking of the DAC programming path and as a register-write sink for boards that emulate the DAC.

Parameters:
- FRAME_BITS, 24, bits per frame; a frame is valid only with exactly this many SCLK falling edges.
- SYNC_STAGES, 2, flip-flop synchronizer depth on each serial input (minimum 2).
- FIFO_DEPTH, 4, received-frame FIFO entries (power of 2, minimum 2).

Ports:
- clk  input  1  sampling clock; frequency ≥ 4× ser_clk.
- reset_n  input  1  asynchronous, active-low reset.
- ser_clk  input  1  serial clock, asynchronous to clk.
- ser_nsync  input  1  frame sync, active low, asynchronous.
- ser_din  input  1  serial data, sampled on ser_clk falling edge.
- frame_data  output  FRAME_BITS  head-of-FIFO frame.
- frame_valid  output  1  FIFO non-empty.
- frame_ready  input  1  consumer accept; pop occurs when valid&&ready.
- err_short  output  1  one-cycle pulse: frame ended with 1..FRAME_BITS-1 bits.
- err_long  output  1  one-cycle pulse: extra falling edge after FRAME_BITS bits.
- overflow  output  1  one-cycle pulse: good frame dropped because the FIFO is full.
- busy  output  1  high while in SHIFT or DRAIN.

Behaviour:
- Reset values:
  - All outputs 0; frame_data 0.
  - Synchronizer chains reset to 1 for nsync and ser_clk, 0 for din.
  - FSM resets to WAIT_IDLE; FIFO empty; bit_cnt 0.
- Input conditioning:
  - Each input passes through SYNC_STAGES flops, then one history flop for edge detect.
  - Falling edge = prev 1, current 0; rising edge = prev 0, current 1.
- FSM:
  - WAIT_IDLE: go to IDLE when synchronized nsync = 1. Prevents a frame already in progress at reset release from being captured.
  - IDLE: nsync falling → SHIFT; clear shift register and bit_cnt.
  - SHIFT:
    - On ser_clk falling edge with nsync low: shift in din at LSB (MSB-first on the wire) and increment bit_cnt.
    - A falling edge arriving with bit_cnt == FRAME_BITS → pulse err_long, go to DRAIN.
    - On nsync rising:
      - bit_cnt == FRAME_BITS → push if not full, otherwise pulse overflow and drop.
      - 1 ≤ bit_cnt < FRAME_BITS → pulse err_short.
      - bit_cnt == 0 → ignore silently.
      - In all cases go to IDLE.
  - DRAIN: ignore clocks; on nsync rising go to IDLE. No frame is pushed.
- Simultaneous events:
  - If ser_clk falling and nsync rising are detected in the same cycle, the edge is ignored and the frame end is processed.
- bit_cnt: $clog2(FRAME_BITS+1) bits; saturates at FRAME_BITS.
- Latency:
  - frame_valid rises exactly SYNC_STAGES+2 clk cycles after the nsync rising edge is first sampled by the stage-1 flop.
  - This holds when the FIFO is empty.
- FIFO:
  - First-word fall-through.
  - frame_data is stable while valid && !ready.
  - When full, a pop in the same cycle frees space, so that cycle's push is accepted and no overflow is flagged.
  - Pointers wrap modulo FIFO_DEPTH; a count register distinguishes full from empty.
- Reset mid-frame:
  - The partial frame is discarded and no error pulse is issued.
  - After release, the FSM stays in WAIT_IDLE until nsync is high.

Optional Feature:
- DAC_RX_STATS_EN defined adds three outputs:
  - frame_count[15:0]: frames pushed.
  - error_count[15:0]: err_short + err_long + overflow events.
  - stats_clear (input): synchronous clear.
- Counters saturate at 16'hFFFF; reset to 0.
- Without the macro these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package dac_rx_pkg holds:
  - rx_state_t enum {WAIT_IDLE, IDLE, SHIFT, DRAIN};
  - default FRAME_BITS constant (24);
  - dac_rx_stats_t struct (frame_count, error_count).
- Sub-module dac_rx_fifo: parameterized FWFT FIFO with push/pop/full/empty and the same clk/reset_n.
- Synchronizers stay inline.

Test Plan:
- Basic frame: send frame 24'hA5_3C_0F with ser_clk = clk/8, ready = 1 → frame_valid pulses once with frame_data = 24'hA53C0F, SYNC_STAGES+2 cycles after nsync rises; no error pulses.
- Short frame: send 23 bits, then a 0-bit frame (nsync toggle only) → err_short pulses exactly once; no push; the 0-bit frame gives no pulse.
- Long frame: send 25 falling edges → err_long pulses at the 25th edge; no push; next frame 24'h000001 is received correctly.
- Overflow:
  - Hold ready = 0 and send 5 frames 1..5 → FIFO holds 1..4 and overflow pulses on frame 5.
  - Then ready = 1 → pops 1, 2, 3, 4 in order.
  - Full + pop in the same cycle as a push → push accepted, no overflow.
- Reset mid-frame: assert reset_n low after 10 bits and release while nsync is still low → no frame and no error until nsync rises; the following full frame 24'hFFFFFF is received.
- Stats (DAC_RX_STATS_EN): 3 good + 2 bad frames → frame_count = 3, error_count = 2; stats_clear → both 0.

Source files
------------

// File: rtl/dac_rx_pkg.sv
// dac_rx_pkg: shared types and helpers for the DAC serial receiver.
// Holds the receive FSM state type, the default frame width, the statistics
// record and a saturating 16-bit adder used by the optional statistics counters.
package dac_rx_pkg;
  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, DRAIN} rx_state_t;
  localparam int FRAME_BITS_DEF = 24;
  typedef struct packed {
    logic [15:0] frame_count;
    logic [15:0] error_count;
  } dac_rx_stats_t;
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {15'd0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/dac_rx_fifo.sv
// dac_rx_fifo: first-word fall-through FIFO for received frames.
// Ports: clk, reset_n (async active-low); push/wdata write request;
// pop read request; rdata head entry (0 when empty); full, empty flags;
// accept high when the push request is actually written (a same-cycle pop
// frees room in a full FIFO).
module dac_rx_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         accept
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          do_pop;
  assign empty  = cnt_q == '0;
  assign full   = cnt_q == (AW+1)'(DEPTH);
  assign do_pop = pop && !empty;
  assign accept = push && (!full || do_pop);
  assign rdata  = empty ? '0 : mem_q[rd_q];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= accept ? wr_q + 1'b1 : wr_q;
      rd_q  <= do_pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + {{AW{1'b0}}, accept} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/dac_serial_receiver.sv
// dac_serial_receiver: oversampling slave receiver for the 3-wire DAC programming port.
// Inputs ser_clk/ser_nsync/ser_din are synchronized into clk, MSB-first frames of
// FRAME_BITS are deserialized and well-formed frames pushed into a FWFT FIFO
// (frame_data/frame_valid/frame_ready). err_short, err_long and overflow are
// one-cycle pulses; busy is high while a frame is being shifted or drained.
// Define DAC_RX_STATS_EN to add frame_count/error_count outputs and stats_clear input.
module dac_serial_receiver
  import dac_rx_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ser_clk,
  input  logic                  ser_nsync,
  input  logic                  ser_din,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  err_short,
  output logic                  err_long,
  output logic                  overflow,
  output logic                  busy
`ifdef DAC_RX_STATS_EN
  ,
  output logic [15:0]           frame_count,
  output logic [15:0]           error_count,
  input  logic                  stats_clear
`endif
);
  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FRAME_BITS);
  localparam int L = SYNC_STAGES - 1;
  logic [L:0] sclk_q, nsync_q, din_q;
  logic sclk_h_q, nsync_h_q, din_h_q;
  logic sclk_fall_q, nsync_fall_q, nsync_rise_q;
  logic [SYNC_STAGES+1:0] prime_q;
  rx_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d;
  logic push_q, push_d, es_q, es_d, el_q, el_d, ov_q;
  logic full, empty, accept;
  // Edge flags are registered so they line up with the history flops: the
  // level in nsync_h_q and the data in din_h_q belong to the same sample.
  // prime_q keeps WAIT_IDLE closed until the reset values have flushed out of
  // the chains, so a frame already in progress at reset release is not seen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_q       <= '1;
      nsync_q      <= '1;
      din_q        <= '0;
      sclk_h_q     <= 1'b1;
      nsync_h_q    <= 1'b1;
      din_h_q      <= 1'b0;
      sclk_fall_q  <= 1'b0;
      nsync_fall_q <= 1'b0;
      nsync_rise_q <= 1'b0;
      prime_q      <= '0;
    end else begin
      sclk_q       <= {sclk_q[L-1:0], ser_clk};
      nsync_q      <= {nsync_q[L-1:0], ser_nsync};
      din_q        <= {din_q[L-1:0], ser_din};
      sclk_h_q     <= sclk_q[L];
      nsync_h_q    <= nsync_q[L];
      din_h_q      <= din_q[L];
      sclk_fall_q  <= sclk_h_q & ~sclk_q[L];
      nsync_fall_q <= nsync_h_q & ~nsync_q[L];
      nsync_rise_q <= ~nsync_h_q & nsync_q[L];
      prime_q      <= {prime_q[SYNC_STAGES:0], 1'b1};
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    push_d  = 1'b0;
    es_d    = 1'b0;
    el_d    = 1'b0;
    case (state_q)
      WAIT_IDLE: state_d = (prime_q[SYNC_STAGES+1] && nsync_h_q) ? IDLE : WAIT_IDLE;
      IDLE: if (nsync_fall_q) begin
        state_d = SHIFT;
        cnt_d   = '0;
        sr_d    = '0;
      end
      // A frame end wins over a coincident serial clock edge.
      SHIFT: if (nsync_rise_q) begin
        state_d = IDLE;
        push_d  = cnt_q == FULL_CNT;
        es_d    = cnt_q != '0 && cnt_q != FULL_CNT;
      end else if (sclk_fall_q && !nsync_h_q) begin
        if (cnt_q == FULL_CNT) begin
          el_d    = 1'b1;
          state_d = DRAIN;
        end else begin
          sr_d  = {sr_q[FRAME_BITS-2:0], din_h_q};
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = nsync_rise_q ? IDLE : DRAIN;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      push_q  <= 1'b0;
      es_q    <= 1'b0;
      el_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      push_q  <= push_d;
      es_q    <= es_d;
      el_q    <= el_d;
      ov_q    <= push_q & ~accept;
    end
  end
  dac_rx_fifo #(.W(FRAME_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (push_q),
    .wdata  (sr_q),
    .pop    (frame_ready),
    .rdata  (frame_data),
    .full   (full),
    .empty  (empty),
    .accept (accept)
  );
  assign frame_valid = ~empty;
  assign err_short   = es_q;
  assign err_long    = el_q;
  assign overflow    = ov_q;
  assign busy        = state_q == SHIFT || state_q == DRAIN;
`ifdef DAC_RX_STATS_EN
  dac_rx_stats_t st_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) st_q <= '0;
    else if (stats_clear) st_q <= '0;
    else begin
      st_q.frame_count <= sat_add(st_q.frame_count, {1'b0, accept});
      st_q.error_count <= sat_add(st_q.error_count, {1'b0, es_q} + {1'b0, el_q} + {1'b0, ov_q});
    end
  end
  assign frame_count = st_q.frame_count;
  assign error_count = st_q.error_count;
`endif
endmodule

// File: tb/tb_dac_serial_receiver.sv
// tb_dac_serial_receiver: directed and randomized frames checked against a frame-level model.
module tb_dac_serial_receiver;
  localparam int FB  = 24;
  localparam int SS  = 2;
  localparam int DEP = 4;
  logic clk = 1'b0, reset_n = 1'b0, ser_clk = 1'b1, ser_nsync = 1'b1, ser_din = 1'b0, frame_ready = 1'b0;
  logic [FB-1:0] frame_data;
  logic frame_valid, err_short, err_long, overflow, busy;
`ifdef DAC_RX_STATS_EN
  logic [15:0] frame_count, error_count;
  logic stats_clear = 1'b0;
`endif
  dac_serial_receiver #(.FRAME_BITS(FB), .SYNC_STAGES(SS), .FIFO_DEPTH(DEP)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .ser_clk    (ser_clk),
    .ser_nsync  (ser_nsync),
    .ser_din    (ser_din),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_ready(frame_ready),
    .err_short  (err_short),
    .err_long   (err_long),
    .overflow   (overflow),
    .busy       (busy)
`ifdef DAC_RX_STATS_EN
    ,
    .frame_count(frame_count),
    .error_count(error_count),
    .stats_clear(stats_clear)
`endif
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0;
  int n_short = 0, n_long = 0, n_ov = 0;
  int e_short = 0, e_long = 0, e_ov = 0;
  logic [FB-1:0] got[$], exp_out[$], mq[$];
  always @(negedge clk) begin
    if (reset_n) begin
      n_short += int'(err_short);
      n_long  += int'(err_long);
      n_ov    += int'(overflow);
      if (frame_valid && frame_ready) got.push_back(frame_data);
    end
  end
  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic bits(input int n, input logic [31:0] d);
    ser_nsync = 1'b0;
    step(4);
    for (int i = n - 1; i >= 0; i--) begin
      ser_din = d[i];
      step(4);
      ser_clk = 1'b0;
      step(4);
      ser_clk = 1'b1;
    end
  endtask
  task automatic close_frame();
    step(4);
    ser_nsync = 1'b1;
  endtask
  // Frame-level outcome: exactly FB edges is a frame, fewer (but some) is short, more is long.
  task automatic model(input int n, input logic [31:0] d);
    if (n == FB) begin
      if (frame_ready) exp_out.push_back(d[FB-1:0]);
      else if (mq.size() < DEP) mq.push_back(d[FB-1:0]);
      else e_ov++;
    end else if (n > FB) e_long++;
    else if (n > 0) e_short++;
  endtask
  task automatic frame(input int n, input logic [31:0] d);
    model(n, d);
    bits(n, d);
    close_frame();
    step(20);
  endtask
  task automatic cmp_all(input string tag);
    int m;
    chk({tag, "_count"}, got.size(), exp_out.size());
    m = got.size() < exp_out.size() ? got.size() : exp_out.size();
    for (int i = 0; i < m; i++) chk({tag, "_data"}, 32'(got[i]), 32'(exp_out[i]));
    chk({tag, "_short"}, n_short, e_short);
    chk({tag, "_long"}, n_long, e_long);
    chk({tag, "_ovf"}, n_ov, e_ov);
    got.delete();
    exp_out.delete();
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end
  initial begin
    int lat, n, r;
    logic [31:0] d;
    step(3);
    chk("rst_valid", frame_valid, 0);
    chk("rst_data", frame_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_short", err_short, 0);
    chk("rst_long", err_long, 0);
    chk("rst_ovf", overflow, 0);
    reset_n = 1'b1;
    step(10);
    frame_ready = 1'b1;
    model(FB, 32'hA53C0F);
    bits(FB, 32'hA53C0F);
    chk("busy_shift", busy, 1);
    close_frame();
    step(1);
    lat = 0;
    while (!frame_valid && lat < 40) begin
      step(1);
      lat++;
    end
    chk("latency", lat, SS + 2);
    chk("basic_head", frame_data, 24'hA53C0F);
    step(1);
    chk("valid_pulse", frame_valid, 0);
    step(20);
    cmp_all("basic");
    frame(23, $urandom);
    frame(0, 0);
    cmp_all("short");
    model(25, 32'h1ABCDEF);
    bits(25, 32'h1ABCDEF);
    step(10);
    chk("long_before_end", n_long, 1);
    chk("busy_drain", busy, 1);
    close_frame();
    step(20);
    frame(FB, 32'h000001);
    cmp_all("long");
    frame_ready = 1'b0;
    for (int k = 1; k <= 5; k++) frame(FB, k);
    chk("ovf_count", n_ov, e_ov);
    chk("held_head", frame_data, 1);
    step(7);
    chk("held_stable", frame_data, 1);
    chk("held_valid", frame_valid, 1);
    exp_out.push_back(mq.pop_front());
    mq.push_back(24'd6);
    bits(FB, 6);
    close_frame();
    step(1);
    step(SS + 1);
    frame_ready = 1'b1;
    step(1);
    frame_ready = 1'b0;
    step(20);
    chk("fullpop_ovf", n_ov, e_ov);
    chk("fullpop_head", frame_data, 2);
    while (mq.size() > 0) exp_out.push_back(mq.pop_front());
    frame_ready = 1'b1;
    step(DEP + 4);
    cmp_all("overflow");
    bits(10, $urandom);
    reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;
    bits(14, $urandom);
    chk("rst_mid_busy", busy, 0);
    close_frame();
    step(20);
    frame(FB, 32'hFFFFFF);
    cmp_all("reset_mid");
    for (int k = 0; k < 12; k++) begin
      r = $urandom_range(0, 5);
      n = (r == 2) ? $urandom_range(1, FB - 1) : (r == 3) ? $urandom_range(FB + 1, FB + 3) : (r == 4) ? 0 : FB;
      d = $urandom;
      frame(n, d);
      step($urandom_range(0, 7));
    end
    cmp_all("random");
`ifdef DAC_RX_STATS_EN
    stats_clear = 1'b1;
    step(1);
    stats_clear = 1'b0;
    for (int k = 0; k < 3; k++) frame(FB, $urandom);
    frame(10, $urandom);
    frame(FB + 2, $urandom);
    chk("stats_frames", frame_count, 3);
    chk("stats_errors", error_count, 2);
    stats_clear = 1'b1;
    step(1);
    stats_clear = 1'b0;
    chk("stats_clr_frames", frame_count, 0);
    chk("stats_clr_errors", error_count, 0);
    cmp_all("stats");
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
